// File: rtl/bus_arbiter.sv
// N-way bus arbiter with registered one-hot grant, hold-time watchdog and encoded owner index.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest asserted index wins.
module bus_arbiter #(
    parameter int unsigned NUM_REQ        = 5,
    parameter int unsigned IDX_WIDTH      = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   bus_reqcyc,
    input  logic                 bus_busy,
    output logic [NUM_REQ-1:0]   bus_grant,
    output logic                 grant_valid,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_d;
    logic [IDX_WIDTH-1:0]   idx_d;
    logic                   timeout_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]   win;
    logic                   found;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [IDX_WIDTH-1:0]   last_owner_q, last_owner_d;
`endif

    // Winner selection over the current request vector
    always_comb begin
        int cand;
        win   = '0;
        found = 1'b0;
        cand  = 0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = (int'(last_owner_q) + 1 + i) % int'(NUM_REQ);
            if (!found && bus_reqcyc[IDX_WIDTH'(cand)]) begin
                win   = IDX_WIDTH'(cand);
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = i;
            if (!found && bus_reqcyc[IDX_WIDTH'(cand)]) begin
                win   = IDX_WIDTH'(cand);
                found = 1'b1;
            end
        end
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        grant_d   = '0;
        idx_d     = '0;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus_busy && found) begin
                    state_d = GRANTED;
                    grant_d = NUM_REQ'(1) << win;
                    idx_d   = win;
                    cnt_d   = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    last_owner_d = win;
`endif
                end
            end
            GRANTED: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                if (!bus_reqcyc[grant_idx]) begin
                    state_d = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    grant_d = bus_grant;
                    idx_d   = grant_idx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_grant   <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
            cnt_q       <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_owner_q <= IDX_WIDTH'(NUM_REQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            bus_grant   <= grant_d;
            grant_valid <= |grant_d;
            grant_idx   <= idx_d;
            timeout     <= timeout_d;
            cnt_q       <= cnt_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

endmodule
